// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB-Lite bus arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BURST = 2'd2,
        ST_LOCK  = 2'd3
    } arb_state_e;

    // Beats in a burst; 0 stands for an unbounded INCR.
    function automatic logic [4:0] beats_of(input logic [2:0] hburst);
        case (hburst)
            HB_SINGLE:           return 5'd1;
            HB_INCR:             return 5'd0;
            HB_WRAP4, HB_INCR4:  return 5'd4;
            HB_WRAP8, HB_INCR8:  return 5'd8;
            default:             return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin pick: search from last+1 upward, last owner checked last.
module ahb_rr_picker #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [MW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = MW'((int'(last) + i) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_lite_arbiter.sv
// AHB-Lite multi-master arbiter: grant FSM, beat counter, lock tracking and
// the hmaster / hmaster_data select pipeline.
//
// state | meaning
// PARK  | DEFAULT_MASTER holds the grant, nobody requesting
// OWN   | grant held for single transfers or INCR
// BURST | fixed-length burst in progress, beat counter active
// LOCK  | owner runs a locked sequence, rearbitration suppressed
module ahb_lite_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_data,
    output logic                   hmastlock
);

    localparam logic [NUM_MASTERS-1:0] GNT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

    arb_state_e             state, state_n;
    logic [4:0]             cnt, cnt_n, nbeats;
    logic [NUM_MASTERS-1:0] gnt_n, pick_gnt;
    logic [MW-1:0]          gnt_idx;
    logic                   pick_valid, hlock_q;
    logic                   settled, last_beat, incr_drop, burst_hold, fixed_burst, rearb;

    ahb_rr_picker #(.N(NUM_MASTERS), .MW(MW)) u_picker (
        .req   (hbusreq),
        .last  (gnt_idx),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i]) gnt_idx = MW'(i);
        end
    end

    assign nbeats      = beats_of(hburst);
    assign fixed_burst = (nbeats > 5'd1);
    // Handover is only decided once the granted master actually owns the address phase.
    assign settled     = (hmaster == gnt_idx);
    assign last_beat   = (htrans == HT_SEQ && state == ST_BURST && cnt == 5'd1) ||
                         (htrans == HT_NONSEQ && hburst == HB_SINGLE);
    assign incr_drop   = (hburst == HB_INCR) && !hbusreq[gnt_idx];
    assign burst_hold  = (state == ST_BURST) && !last_beat;
    assign hmastlock   = (state == ST_LOCK) && hlock_q;

    always_comb begin
        rearb = 1'b0;
        if (hready && settled) begin
            if (state == ST_LOCK)
                rearb = !hlock[gnt_idx] && (htrans != HT_BUSY);
            else
                rearb = !burst_hold && (htrans == HT_IDLE || last_beat || incr_drop);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_n   = hgrant;
        case (state)
            ST_PARK, ST_OWN: begin
                if (htrans == HT_NONSEQ && fixed_burst) begin
                    state_n = ST_BURST;
                    cnt_n   = nbeats - 5'd1;
                end
            end
            ST_BURST: begin
                if (htrans == HT_SEQ) begin
                    cnt_n = cnt - 5'd1;
                    if (cnt == 5'd1) state_n = ST_OWN;
                end else if (htrans != HT_BUSY) begin
                    cnt_n   = '0;
                    state_n = ST_OWN;
                end
            end
            default: ;
        endcase
        if (rearb) begin
            cnt_n = '0;
            if (hbusreq[gnt_idx] && hlock[gnt_idx]) begin
                state_n = ST_LOCK;
            end else if (pick_valid) begin
                gnt_n   = pick_gnt;
                state_n = ST_OWN;
            end else begin
                gnt_n   = GNT_RST;
                state_n = ST_PARK;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state        <= ST_PARK;
            cnt          <= '0;
            hgrant       <= GNT_RST;
            hmaster      <= DEF_IDX;
            hmaster_data <= DEF_IDX;
            hlock_q      <= 1'b0;
        end else if (hready) begin
            state        <= state_n;
            cnt          <= cnt_n;
            hgrant       <= gnt_n;
            hmaster      <= gnt_idx;
            hmaster_data <= hmaster;
            hlock_q      <= hlock[gnt_idx];
        end
    end

endmodule
